alu_op_arbiter: RTL and testbench
=================================

# alu_op_arbiter

Round-robin arbiter and sequencer that shares one 8-bit ALU (add/sub/and/or/xor selected by a 3-bit opcode) among several requesters. It accepts at most one operation per cycle over per-requester valid/ready handshakes and executes it in a registered ALU stage. It returns the result, tagged with the requester index, through a single-entry output buffer with backpressure. It sits between the issuing agents and the downstream consumer of ALU results.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 8, operand/result width
- ID_W, $clog2(NUM_REQ), derived localparam, requester index width
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester operation valid
- req_ready  output  NUM_REQ  per-requester accept, at most one bit high (one-hot or zero)
- req_opcode  input  3*NUM_REQ  packed opcodes, requester i at [3i+2:3i]
- req_a  input  DATA_W*NUM_REQ  packed operand A
- req_b  input  DATA_W*NUM_REQ  packed operand B
- rsp_valid  output  1  result buffer holds a result
- rsp_ready  input  1  downstream accepts the result
- rsp_id  output  ID_W  index of the requester that issued the result
- rsp_result  output  DATA_W  ALU result
- rsp_err  output  1  illegal opcode flag (present only with the macro, see Configuration)
- busy  output  1  rsp_valid OR any req_valid

## Operation
- Buffer FSM: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY OR (FULL AND rsp_ready).
- Arbiter:
  - If can_accept, grant the first i with req_valid[i]=1, scanning from (last_grant+1) mod NUM_REQ upward with wrap-around.
  - req_ready[grant]=1, all other bits 0.
  - If nothing is valid, or can_accept=0, req_ready is all zero.
- Accept = req_valid[g] AND req_ready[g]. On accept:
  - last_grant <= g.
  - rsp_id <= g.
  - rsp_result <= ALU(opcode_g, a_g, b_g).
  - FSM -> FULL. This also covers FULL with a drain in the same cycle: a back-to-back replace.
- FULL with rsp_ready=1 and no accept: FSM -> EMPTY. rsp_result/rsp_id keep their last values, which are don't-care.
- FULL with rsp_ready=0: everything holds. rsp_id, rsp_result and rsp_err must not change while rsp_valid=1 and rsp_ready=0.
- ALU opcodes:
  - 000 a+b
  - 001 a-b
  - 010 a&b
  - 011 a|b
  - 100 a^b
  - 101-111 handled by an explicit default: result 0
- ALU width: all arithmetic is modulo 2^DATA_W. Carry and borrow are discarded; no sign extension.
- Requesters must hold opcode/a/b stable while req_valid=1 and not accepted. The block does not check this.
- Fairness: a continuously valid requester is granted within NUM_REQ accepts.

## Timing
- Reset values (asynchronous, immediate):
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0
  - FSM=EMPTY
  - last_grant=NUM_REQ-1, so requester 0 has first priority
- req_ready is combinational from req_valid, rsp_valid, rsp_ready and last_grant. No combinational path from opcode/a/b to any output.
- Latency: accept in cycle N -> rsp_valid=1 with the result in cycle N+1.
- Throughput: one operation per cycle when rsp_ready stays high.
- Reset asserted mid-operation: the held result is dropped with no output, and the round-robin pointer is reinitialised. After rst_n deasserts, the first accept can occur in the first clock edge.

## Configuration
- Macro: ALU_ARB_ILLEGAL_OP_ERR_EN.
- Defined:
  - rsp_err port exists.
  - rsp_err is registered with the result: 1 when the accepted opcode is 101-111, else 0.
  - rsp_result is 0 for illegal opcodes.
- Undefined:
  - rsp_err port and its logic are absent.
  - Illegal opcodes silently produce rsp_result=0.
- All other behaviour is identical in both builds.

## Test plan
- Single op: after reset, req_valid[2]=1, opcode 000, a=8'hF0, b=8'h20 -> req_ready[2]=1 that cycle; next cycle rsp_valid=1, rsp_id=2, rsp_result=8'h10 (carry dropped).
- Opcode sweep from requester 0 with a=8'h0F, b=8'h3C, rsp_ready=1, opcodes 000..111 -> results 4B, D3, 0C, 3F, 33, 00, 00, 00, one per cycle. With the macro, rsp_err=1 exactly for the last three.
- Round-robin: all four req_valid held high, rsp_ready=1 -> grant order 0,1,2,3,0,1,... with exactly one req_ready bit per cycle.
- Backpressure: rsp_ready=0 for 5 cycles while FULL -> req_ready all zero, rsp_* stable. Raise rsp_ready with req_valid[1] pending -> replace in the same cycle, new rsp_id=1 next cycle.
- Drain to empty: FULL, rsp_ready=1, no req_valid -> rsp_valid=0 next cycle and busy=0.
- Reset mid-stream: assert rst_n=0 while FULL with rsp_ready=0 -> rsp_valid drops immediately. After release with all req_valid high, the first grant is requester 0.

Source files
------------

// File: rtl/alu_op_arbiter.sv
// Round-robin arbiter sharing one registered 8-bit ALU across requesters.
// Optional illegal-opcode flag: define ALU_ARB_ILLEGAL_OP_ERR_EN.
module alu_op_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W = 8,
    localparam int ID_W = $clog2(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [3*NUM_REQ-1:0]  req_opcode,
    input  logic [DATA_W*NUM_REQ-1:0] req_a,
    input  logic [DATA_W*NUM_REQ-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [DATA_W-1:0]     rsp_result,
`ifdef ALU_ARB_ILLEGAL_OP_ERR_EN
    output logic                  rsp_err,
`endif
    output logic                  busy
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    logic [0:0]        state;
    logic [ID_W-1:0]   last_grant;
    logic [ID_W-1:0]   grant;
    logic              found;
    logic              can_accept;
    logic              accept;
    logic [2:0]        op;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
    logic [DATA_W-1:0] alu_res;

    assign rsp_valid  = (state == FULL);
    assign can_accept = (state == EMPTY) || rsp_ready;
    assign accept     = can_accept && found;
    assign busy       = rsp_valid || (|req_valid);

    // Scan requesters starting just after the last grant, with wrap-around.
    always_comb begin
        int idx;
        idx   = 0;
        grant = '0;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(last_grant) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = ID_W'(idx);
            end
        end
    end

    // Only the granted requester sees ready, and only when the buffer can take it.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grant] = 1'b1;
        end
    end

    // Select the granted requester's opcode and operands.
    always_comb begin
        op  = '0;
        opa = '0;
        opb = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant == ID_W'(i)) begin
                op  = req_opcode[3*i +: 3];
                opa = req_a[DATA_W*i +: DATA_W];
                opb = req_b[DATA_W*i +: DATA_W];
            end
        end
    end

    // ALU; arithmetic wraps at DATA_W bits, unused opcodes give zero.
    always_comb begin
        case (op)
            3'b000:  alu_res = opa + opb;
            3'b001:  alu_res = opa - opb;
            3'b010:  alu_res = opa & opb;
            3'b011:  alu_res = opa | opb;
            3'b100:  alu_res = opa ^ opb;
            default: alu_res = '0;
        endcase
    end

    // Buffer state, round-robin pointer and registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= EMPTY;
            last_grant <= ID_W'(NUM_REQ - 1);
            rsp_id     <= '0;
            rsp_result <= '0;
        end else if (accept) begin
            state      <= FULL;
            last_grant <= grant;
            rsp_id     <= grant;
            rsp_result <= alu_res;
        end else if (state == FULL && rsp_ready) begin
            state <= EMPTY;
        end
    end

`ifdef ALU_ARB_ILLEGAL_OP_ERR_EN
    // Illegal-opcode flag travels with the result it describes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err <= 1'b0;
        end else if (accept) begin
            rsp_err <= (op > 3'b100);
        end
    end
`endif

endmodule

// File: tb/tb_alu_op_arbiter.sv
// Self-checking bench for alu_op_arbiter with a transaction-level model.
// Build with ALU_ARB_ILLEGAL_OP_ERR_EN defined to also check rsp_err.
module tb_alu_op_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req_valid = '0;
    logic [N-1:0] req_ready;
    logic [3*N-1:0] req_opcode = '0;
    logic [W*N-1:0] req_a = '0;
    logic [W*N-1:0] req_b = '0;
    logic rsp_valid;
    logic rsp_ready = 1'b0;
    logic [1:0] rsp_id;
    logic [W-1:0] rsp_result;
    logic busy;
`ifdef ALU_ARB_ILLEGAL_OP_ERR_EN
    logic rsp_err;
`endif

    int total = 0;
    int bad = 0;

    // Model: round-robin pointer and a one-slot result buffer.
    int m_last = N - 1;
    bit m_full = 0;
    int m_id = 0;
    logic [W-1:0] m_res = '0;
    bit m_err = 0;

    always #5 clk = ~clk;

    alu_op_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_opcode(req_opcode),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_result(rsp_result),
`ifdef ALU_ARB_ILLEGAL_OP_ERR_EN
        .rsp_err(rsp_err),
`endif
        .busy(busy)
    );

    function automatic logic [W-1:0] alu_ref(input logic [2:0] o,
                                             input logic [W-1:0] a,
                                             input logic [W-1:0] b);
        int s;
        case (o)
            3'd0: s = (int'(a) + int'(b)) % 256;
            3'd1: s = (int'(a) - int'(b) + 256) % 256;
            3'd2: s = int'(a & b);
            3'd3: s = int'(a | b);
            3'd4: s = int'(a ^ b);
            default: s = 0;
        endcase
        return W'(s);
    endfunction

    function automatic int exp_grant();
        if (m_full && !rsp_ready) return -1;
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        g = exp_grant();
        if (g < 0) return '0;
        return N'(1) << g;
    endfunction

    task automatic model_reset();
        m_last = N - 1;
        m_full = 0;
        m_id = 0;
        m_res = '0;
        m_err = 0;
    endtask

    task automatic set_req(input int i, input bit v, input logic [2:0] o,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid[i] = v;
        req_opcode[3*i +: 3] = o;
        req_a[W*i +: W] = a;
        req_b[W*i +: W] = b;
    endtask

    // Advance one clock and move the model with the pre-edge inputs.
    task automatic clk_step();
        int g;
        g = exp_grant();
        @(posedge clk);
        if (g >= 0) begin
            m_last = g;
            m_full = 1;
            m_id = g;
            m_res = alu_ref(req_opcode[3*g +: 3], req_a[W*g +: W], req_b[W*g +: W]);
            m_err = (req_opcode[3*g +: 3] > 3'd4);
        end else if (m_full && rsp_ready) begin
            m_full = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        #3;
        total++;
        if (rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_result !== 8'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset: valid=%b id=%0d res=%h busy=%b want 0 0 00 0",
                     rsp_valid, rsp_id, rsp_result, busy);
        end
`ifdef ALU_ARB_ILLEGAL_OP_ERR_EN
        total++;
        if (rsp_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_err: got %b want 0", rsp_err);
        end
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_op();
        set_req(2, 1, 3'd0, 8'hF0, 8'h20);
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0100) begin
            bad++;
            $display("FAIL single_ready: got %b want 0100", req_ready);
        end
        clk_step();
        req_valid = '0;
        #1;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_result !== 8'h10) begin
            bad++;
            $display("FAIL single_rsp: v=%b id=%0d res=%h want 1 2 10",
                     rsp_valid, rsp_id, rsp_result);
        end
    endtask

    task automatic test_opcode_sweep();
        logic [W-1:0] want [8];
        want = '{8'h4B, 8'hD3, 8'h0C, 8'h3F, 8'h33, 8'h00, 8'h00, 8'h00};
        rsp_ready = 1'b1;
        for (int o = 0; o < 8; o++) begin
            set_req(0, 1, 3'(o), 8'h0F, 8'h3C);
            #1;
            total++;
            if (req_ready !== 4'b0001) begin
                bad++;
                $display("FAIL sweep_ready op=%0d: got %b want 0001", o, req_ready);
            end
            clk_step();
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== want[o]) begin
                bad++;
                $display("FAIL sweep op=%0d: v=%b id=%0d res=%h want 1 0 %h",
                         o, rsp_valid, rsp_id, rsp_result, want[o]);
            end
`ifdef ALU_ARB_ILLEGAL_OP_ERR_EN
            total++;
            if (rsp_err !== (o >= 5)) begin
                bad++;
                $display("FAIL sweep_err op=%0d: got %b want %b", o, rsp_err, o >= 5);
            end
`endif
        end
        req_valid = '0;
    endtask

    task automatic test_round_robin();
        int e;
        for (int i = 0; i < N; i++) set_req(i, 1, 3'd0, 8'(i), 8'd1);
        rsp_ready = 1'b1;
        for (int c = 0; c < 2 * N; c++) begin
            e = (m_last + 1) % N;
            #1;
            total++;
            if (req_ready !== (N'(1) << e)) begin
                bad++;
                $display("FAIL rr_ready c=%0d: got %b want grant %0d", c, req_ready, e);
            end
            clk_step();
            total++;
            if (rsp_id !== 2'(e) || rsp_result !== 8'(e + 1)) begin
                bad++;
                $display("FAIL rr_rsp c=%0d: id=%0d res=%h want %0d %h",
                         c, rsp_id, rsp_result, e, e + 1);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [W-1:0] hold_res;
        int hold_id;
        hold_res = m_res;
        hold_id = m_id;
        rsp_ready = 1'b0;
        set_req(1, 1, 3'd4, 8'hA5, 8'h5A);
        for (int c = 0; c < 5; c++) begin
            #1;
            total++;
            if (req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_ready c=%0d: got %b want 0000", c, req_ready);
            end
            clk_step();
            total++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(hold_id) || rsp_result !== hold_res) begin
                bad++;
                $display("FAIL bp_hold c=%0d: v=%b id=%0d res=%h want 1 %0d %h",
                         c, rsp_valid, rsp_id, rsp_result, hold_id, hold_res);
            end
        end
        rsp_ready = 1'b1;
        #1;
        total++;
        if (req_ready !== 4'b0010) begin
            bad++;
            $display("FAIL bp_replace_ready: got %b want 0010", req_ready);
        end
        clk_step();
        req_valid = '0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_result !== 8'hFF) begin
            bad++;
            $display("FAIL bp_replace: v=%b id=%0d res=%h want 1 1 ff",
                     rsp_valid, rsp_id, rsp_result);
        end
    endtask

    task automatic test_drain();
        req_valid = '0;
        rsp_ready = 1'b1;
        clk_step();
        total++;
        if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL drain: v=%b busy=%b want 0 0", rsp_valid, busy);
        end
    endtask

    task automatic test_reset_mid();
        set_req(3, 1, 3'd3, 8'h12, 8'h40);
        rsp_ready = 1'b0;
        clk_step();
        req_valid = '0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_result !== 8'h52) begin
            bad++;
            $display("FAIL mid_fill: v=%b res=%h want 1 52", rsp_valid, rsp_result);
        end
        #1 rst_n = 1'b0;
        #1;
        total++;
        if (rsp_valid !== 1'b0 || rsp_result !== 8'h00) begin
            bad++;
            $display("FAIL mid_async: v=%b res=%h want 0 00", rsp_valid, rsp_result);
        end
        for (int i = 0; i < N; i++) set_req(i, 1, 3'd2, 8'hFF, 8'(16 * i + 1));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        #1;
        total++;
        if (req_ready !== 4'b0001) begin
            bad++;
            $display("FAIL mid_first_ready: got %b want 0001", req_ready);
        end
        clk_step();
        req_valid = '0;
        total++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_result !== 8'h01) begin
            bad++;
            $display("FAIL mid_first: v=%b id=%0d res=%h want 1 0 01",
                     rsp_valid, rsp_id, rsp_result);
        end
        test_drain();
    endtask

    task automatic test_random();
        int g;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0)
                    set_req(i, 1, 3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            total++;
            if (req_ready !== exp_ready()) begin
                bad++;
                $display("FAIL rand_ready c=%0d: got %b want %b", c, req_ready, exp_ready());
            end
            total++;
            if (rsp_valid !== m_full || busy !== (m_full || (|req_valid))) begin
                bad++;
                $display("FAIL rand_state c=%0d: v=%b busy=%b want %b %b",
                         c, rsp_valid, busy, m_full, m_full || (|req_valid));
            end
            if (m_full) begin
                total++;
                if (rsp_id !== 2'(m_id) || rsp_result !== m_res) begin
                    bad++;
                    $display("FAIL rand_rsp c=%0d: id=%0d res=%h want %0d %h",
                             c, rsp_id, rsp_result, m_id, m_res);
                end
`ifdef ALU_ARB_ILLEGAL_OP_ERR_EN
                total++;
                if (rsp_err !== m_err) begin
                    bad++;
                    $display("FAIL rand_err c=%0d: got %b want %b", c, rsp_err, m_err);
                end
`endif
            end
            g = exp_grant();
            clk_step();
            if (g >= 0) req_valid[g] = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_opcode_sweep();
        test_round_robin();
        test_backpressure();
        test_drain();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
